alu_cdb_unit: RTL

- Functional unit directly downstream of the reserve station.
- Accepts dispatched ALU instructions (`instruction_out` / `run`) and executes them. Single-cycle ops take one cycle; MUL runs in a 3-stage pipeline.
- Results are buffered and broadcast on the common data bus (CDB) as the 23-bit `solution` word with a `store_cdb` strobe, which the reserve station uses to wake dependents and free entries.
- Arbitration against the memory unit is external, via `cdb_grant`.

---
 rtl/tomasulo_pkg.sv | 90 +++++++++
 rtl/result_fifo.sv | 72 +++++++
 rtl/alu_cdb_unit.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo definitions: widths, opcodes, dispatch/CDB word layouts.
// Used by the ALU/CDB unit and the reserve station.
package tomasulo_pkg;

   localparam int TAG_W   = 3;
   localparam int REG_W   = 4;
   localparam int DATA_W  = 16;
   localparam int OP_W    = 4;
   localparam int INSTR_W = TAG_W + OP_W + REG_W + 2 * DATA_W;
   localparam int SOL_W   = REG_W + TAG_W + DATA_W;

   // Dispatch word field positions
   localparam int IN_C_LO   = 0;
   localparam int IN_C_HI   = 15;
   localparam int IN_B_LO   = 16;
   localparam int IN_B_HI   = 31;
   localparam int IN_DST_LO = 32;
   localparam int IN_DST_HI = 35;
   localparam int IN_OP_LO  = 36;
   localparam int IN_OP_HI  = 39;
   localparam int IN_TAG_LO = 40;
   localparam int IN_TAG_HI = 42;

   // CDB solution word field positions
   localparam int SOL_RES_LO = 0;
   localparam int SOL_RES_HI = 15;
   localparam int SOL_TAG_LO = 16;
   localparam int SOL_TAG_HI = 18;
   localparam int SOL_DST_LO = 19;
   localparam int SOL_DST_HI = 22;

   localparam logic [OP_W-1:0] OP_ADD = 4'b0000;
   localparam logic [OP_W-1:0] OP_SUB = 4'b0001;
   localparam logic [OP_W-1:0] OP_AND = 4'b0010;
   localparam logic [OP_W-1:0] OP_OR  = 4'b0011;
   localparam logic [OP_W-1:0] OP_XOR = 4'b0100;
   localparam logic [OP_W-1:0] OP_SLT = 4'b0101;
   localparam logic [OP_W-1:0] OP_SLL = 4'b0110;
   localparam logic [OP_W-1:0] OP_MUL = 4'b0111;

   typedef struct packed {
      logic [TAG_W-1:0]  tag;
      logic [OP_W-1:0]   op;
      logic [REG_W-1:0]  dest;
      logic [DATA_W-1:0] b;
      logic [DATA_W-1:0] c;
   } dispatch_t;

   typedef struct packed {
      logic [REG_W-1:0]  dest;
      logic [TAG_W-1:0]  tag;
      logic [DATA_W-1:0] result;
   } cdb_word_t;

   typedef struct packed {
      logic              valid;
      logic [TAG_W-1:0]  tag;
      logic [REG_W-1:0]  dest;
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
   } mul_stage_t;

   // Opcode bit 3 marks memory ops, which never execute here
   function automatic logic is_mem_op(input logic [OP_W-1:0] op);
      return op[OP_W-1];
   endfunction

   // Single-cycle ALU; B is the left operand, everything wraps at 16 bits
   function automatic logic [DATA_W-1:0] alu_exec(
      input logic [OP_W-1:0]   op,
      input logic [DATA_W-1:0] b,
      input logic [DATA_W-1:0] c
   );
      logic [DATA_W-1:0] r;
      r = '0;
      case (op)
         OP_ADD:  r = b + c;
         OP_SUB:  r = b - c;
         OP_AND:  r = b & c;
         OP_OR:   r = b | c;
         OP_XOR:  r = b ^ c;
         OP_SLT:  r = ($signed(b) < $signed(c)) ? 16'd1 : 16'd0;
         OP_SLL:  r = b << c[3:0];
         OP_MUL:  r = b * c;
         default: r = '0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/result_fifo.sv
// Show-ahead result FIFO between the writeback slot and the CDB.
// Ports: push_i/data_i write, pop_i drops head data_o, count_o/full_o/empty_o status.
module result_fifo #(
   parameter  int DEPTH = 4,
   parameter  int WIDTH = 23,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clock_i,
   input  logic             reset_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] data_o,
   output logic [CNT_W-1:0] count_o,
   output logic             full_o,
   output logic             empty_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push;
   logic             do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign count_o = count_q;
   assign data_o  = mem_q[rd_ptr_q];

   // A pop when full frees the slot the push lands in this same edge
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clock_i) begin
      if (do_push) mem_q[wr_ptr_q] <= data_i;
   end

   always_ff @(posedge clock_i) begin
      if (!reset_i) begin
         assert (!(push_i && full_o && !pop_i))
            else $error("result_fifo: push when full");
      end
   end

endmodule

// File: rtl/alu_cdb_unit.sv
// ALU functional unit: single-cycle ops plus pipelined MUL, results broadcast on the CDB.
// Ports: run/instruction_in dispatch, ready back-pressure, store_cdb/solution/cdb_grant CDB, busy.
module alu_cdb_unit
   import tomasulo_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int MUL_LAT    = 3
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               run,
   input  logic [INSTR_W-1:0] instruction_in,
   output logic               ready,
   input  logic               cdb_grant,
   output logic               store_cdb,
   output logic [SOL_W-1:0]   solution,
   output logic               busy
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam int OCC_W = CNT_W + 1;

   dispatch_t  disp;
   mul_stage_t mul_s1_q, mul_s1_d;
   mul_stage_t mul_s2_q, mul_s2_d;
   cdb_word_t  wb_q, wb_d;
   logic       wb_valid_q, wb_valid_d;
   logic       err_sticky_q, err_sticky_d;
   logic       err_sticky;

   logic             accept;
   logic             alu_fire;
   logic             mul_fire;
   logic             mem_drop;
   logic [OCC_W-1:0] occ;

   cdb_word_t        fifo_head;
   logic [CNT_W-1:0] fifo_count;
   logic             fifo_full;
   logic             fifo_empty;
   logic             fifo_pop;

   assign disp = dispatch_t'(instruction_in);

   assign accept   = run && ready;
   assign mem_drop = accept && is_mem_op(disp.op);
   assign mul_fire = accept && !is_mem_op(disp.op) && (disp.op == OP_MUL);
   assign alu_fire = accept && !is_mem_op(disp.op) && (disp.op != OP_MUL);

   // Writeback slot and MUL stages count as reserved FIFO space
   assign occ = OCC_W'(fifo_count)
              + OCC_W'(mul_s1_q.valid)
              + OCC_W'(mul_s2_q.valid)
              + OCC_W'(wb_valid_q);

   // s2 leaving next edge would collide with a single-cycle op
   assign ready = !mul_s2_q.valid && (occ < OCC_W'(FIFO_DEPTH));

   assign busy = mul_s1_q.valid || mul_s2_q.valid
              || wb_valid_q || (fifo_count != '0);

   assign err_sticky = err_sticky_q;

   // MUL: s1 latches operands, s2 holds the product, the wb slot is stage three
   always_comb begin
      mul_s1_d       = '0;
      mul_s1_d.valid = mul_fire;
      mul_s1_d.tag   = disp.tag;
      mul_s1_d.dest  = disp.dest;
      mul_s1_d.a     = disp.b;
      mul_s1_d.b     = disp.c;

      mul_s2_d       = '0;
      mul_s2_d.valid = mul_s1_q.valid;
      mul_s2_d.tag   = mul_s1_q.tag;
      mul_s2_d.dest  = mul_s1_q.dest;
      mul_s2_d.a     = mul_s1_q.a * mul_s1_q.b;
   end

   always_comb begin
      wb_d       = '0;
      wb_valid_d = 1'b0;
      unique case (1'b1)
         mul_s2_q.valid: begin
            wb_valid_d  = 1'b1;
            wb_d.dest   = mul_s2_q.dest;
            wb_d.tag    = mul_s2_q.tag;
            wb_d.result = mul_s2_q.a;
         end
         alu_fire: begin
            wb_valid_d  = 1'b1;
            wb_d.dest   = disp.dest;
            wb_d.tag    = disp.tag;
            wb_d.result = alu_exec(disp.op, disp.b, disp.c);
         end
         default: ;
      endcase
   end

   assign err_sticky_d = err_sticky_q || mem_drop;

   always_ff @(posedge clock) begin
      if (reset) begin
         mul_s1_q     <= '0;
         mul_s2_q     <= '0;
         wb_q         <= '0;
         wb_valid_q   <= 1'b0;
         err_sticky_q <= 1'b0;
      end else begin
         mul_s1_q     <= mul_s1_d;
         mul_s2_q     <= mul_s2_d;
         wb_q         <= wb_d;
         wb_valid_q   <= wb_valid_d;
         err_sticky_q <= err_sticky_d;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         assert (MUL_LAT == 3)
            else $error("alu_cdb_unit: only MUL_LAT=3 is supported");
      end
   end

   assign fifo_pop = cdb_grant && !fifo_empty;

   result_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (SOL_W)
   ) u_result_fifo (
      .clock_i (clock),
      .reset_i (reset),
      .push_i  (wb_valid_q),
      .data_i  (wb_q),
      .pop_i   (fifo_pop),
      .data_o  (fifo_head),
      .count_o (fifo_count),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign store_cdb = !fifo_empty;
   assign solution  = fifo_empty ? '0 : fifo_head;

   logic unused_full;
   assign unused_full = fifo_full;

endmodule
